// File: rtl/fifo_rd_axis_stage.sv
// rtl/fifo_rd_axis_stage.sv - read-side AXI-Stream output stage of the Ethernet async FIFO
//
// Pops the FIFO through `read` and absorbs the one-cycle synchronous RAM read
// latency. Words are presented on an AXI-Stream master port at one word per
// cycle. A 3-entry circular buffer gives credit for in-flight RAM reads, so
// `read` depends only on registered state and never on m_axis_tready.
//
// Optional feature macro: FIFO_RD_PKT_CNT_EN adds a saturating 16-bit frame
// counter on the pkt_count port.
//
// Ports:
//   clk            read-domain clock
//   reset_n        asynchronous active-low reset
//   empty          registered FIFO-empty flag from the read-pointer block
//   read           pop request; the word at the current rd_addr is consumed
//   ram_rd_data    synchronous RAM output, bit DATA_WIDTH is the tlast flag
//   m_axis_tdata   stream payload
//   m_axis_tlast   end of frame
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   pkt_count      frames emitted, saturating (FIFO_RD_PKT_CNT_EN only)

module fifo_rd_axis_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  empty,
  output logic                  read,
  input  logic [DATA_WIDTH:0]   ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef FIFO_RD_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_count
`endif
);

  logic [DATA_WIDTH:0] slot [3];
  logic [1:0]          widx;
  logic [1:0]          ridx;
  logic [1:0]          occ;
  logic                inflight;
  logic                handshake;
  logic [2:0]          credit;

  // Advance a circular index over the three slots (2 wraps to 0).
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Words already buffered plus the one the RAM is returning this cycle.
  assign credit = {1'b0, occ} + {2'b00, inflight};

  // Only registered state feeds the pop decision; reset_n gates it so read
  // drops immediately on reset assertion, without waiting for a clock edge.
  assign read = !empty && (credit < 3'd3) && reset_n;

  assign m_axis_tvalid = (occ != 2'd0);
  assign handshake     = m_axis_tvalid && m_axis_tready;

  // Output comes straight from slot storage, so it stays stable until the
  // read index moves on a handshake.
  assign {m_axis_tlast, m_axis_tdata} = slot[ridx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        slot[i] <= '0;
      end
      widx     <= 2'd0;
      ridx     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= read;
      if (inflight) begin
        slot[widx] <= ram_rd_data;
        widx       <= next_idx(widx);
      end
      if (handshake) begin
        ridx <= next_idx(ridx);
      end
      occ <= occ + {1'b0, inflight} - {1'b0, handshake};
    end
  end

`ifdef FIFO_RD_PKT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= 16'h0000;
    end else if (handshake && m_axis_tlast && (pkt_count != 16'hFFFF)) begin
      pkt_count <= pkt_count + 16'h0001;
    end
  end
`endif

  // The credit rule must never let a RAM word land in a full buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
                                   !(inflight && (occ == 2'd3)));

endmodule

// File: tb/tb_fifo_rd_axis_stage.sv
// tb/tb_fifo_rd_axis_stage.sv - directed self-checking bench for fifo_rd_axis_stage

module tb_fifo_rd_axis_stage;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          empty;
  logic          read;
  logic [DW:0]   ram_rd_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
`ifdef FIFO_RD_PKT_CNT_EN
  logic [15:0]   pkt_count;
`endif

  fifo_rd_axis_stage #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .empty         (empty),
    .read          (read),
    .ram_rd_data   (ram_rd_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef FIFO_RD_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents behind the read-pointer block, and expected/received words.
  logic [DW:0] src [$];
  logic [DW:0] exp_q [$];
  logic [DW:0] rx [$];

  int  cyc = 0;
  int  reads, vcycles, first_read, first_valid, last_valid;
  int  popped, hs_cnt, ovf, unstable, rd_while_empty;
  logic last_read;
  logic hold_empty = 1'b0;
  logic rand_ready = 1'b0;
  logic toggle_empty = 1'b0;
  logic prev_valid, prev_hs;
  logic [DW:0] prev_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    reads = 0; vcycles = 0; first_read = -1; first_valid = -1; last_valid = -1;
    popped = 0; hs_cnt = 0; ovf = 0; unstable = 0; rd_while_empty = 0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_word = '0;
    rx.delete(); exp_q.delete();
  endtask

  task automatic set_empty();
    empty = (src.size() == 0) || hold_empty;
  endtask

  // One clock: observe at the falling edge, then update the RAM/empty model
  // just after the rising edge as the registered read-pointer block would.
  task automatic tick();
    logic hs;
    @(negedge clk);
    last_read = read;
    hs = m_axis_tvalid && m_axis_tready;
    if (read) begin
      reads++; popped++;
      if (first_read < 0) first_read = cyc;
    end
    if (read && empty) rd_while_empty++;
    if (prev_valid && !prev_hs &&
        (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} !== prev_word))) unstable++;
    if (m_axis_tvalid) begin
      vcycles++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    if (hs) begin
      hs_cnt++;
      rx.push_back({m_axis_tlast, m_axis_tdata});
    end
    if (popped - hs_cnt > 3) ovf++;
    prev_valid = m_axis_tvalid; prev_hs = hs; prev_word = {m_axis_tlast, m_axis_tdata};
    @(posedge clk);
    #1;
    if (last_read && src.size() > 0) ram_rd_data = src.pop_front();
    if (toggle_empty && (cyc % 2 == 1)) hold_empty = ~hold_empty;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    set_empty();
    cyc++;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base, input int frame_len);
    for (int i = 0; i < n; i++) begin
      logic [DW:0] w;
      w = {((i % frame_len) == frame_len - 1) || (i == n - 1), DW'(base + i)};
      src.push_back(w);
      exp_q.push_back(w);
    end
    set_empty();
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while (rx.size() < exp_q.size() && g < budget) begin
      tick();
      g++;
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic check_rx(input string tag);
    int bad = 0;
    chk({tag, "_count"}, rx.size(), exp_q.size());
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
      if (rx[i] !== exp_q[i]) bad++;
    chk({tag, "_order"}, bad, 0);
  endtask

  initial begin
    reset_n = 1'b0; empty = 1'b1; m_axis_tready = 1'b0; ram_rd_data = '0;
    clear_stats();
    #22;
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_read",   read, 0);
    chk("reset_tdata",  m_axis_tdata, 0);
    chk("reset_tlast",  m_axis_tlast, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(); tick();

    // Single word with last set.
    clear_stats();
    m_axis_tready = 1'b1;
    load(1, 8'hA5, 1);
    drain(20);
    chk("single_reads", reads, 1);
    chk("single_latency", first_valid - first_read, 2);
    chk("single_vcycles", vcycles, 1);
    chk("single_word", rx.size() > 0 ? 32'(rx[0]) : 32'hDEAD, 9'h1A5);

    // Full-rate burst 0x00..0xFF.
    clear_stats();
    load(256, 8'h00, 256);
    drain(400);
    check_rx("burst");
    chk("burst_latency", first_valid - first_read, 2);
    chk("burst_no_bubble", last_valid - first_valid + 1, 256);
    chk("burst_reads", reads, 256);

    // Backpressure mid-burst.
    clear_stats();
    load(20, 8'h40, 20);
    for (int i = 0; i < 6; i++) tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_read_stalled", last_read, 0);
    m_axis_tready = 1'b1;
    tick();
    chk("bp_read_first_ready", last_read, 0);
    tick();
    chk("bp_read_resume", last_read, 1);
    drain(100);
    check_rx("bp");
    chk("bp_overflow", ovf, 0);
    chk("bp_stable", unstable, 0);

    // Empty toggling every two cycles.
    clear_stats();
    toggle_empty = 1'b1;
    load(30, 8'h80, 7);
    drain(300);
    toggle_empty = 1'b0; hold_empty = 1'b0; set_empty();
    check_rx("toggle");
    chk("toggle_rd_empty", rd_while_empty, 0);

    // Reset mid-operation with two words buffered and one in flight.
    clear_stats();
    m_axis_tready = 1'b0;
    load(6, 8'h11, 6);
    tick(); tick(); tick();
    chk("pre_reset_valid", m_axis_tvalid, 1);
    chk("pre_reset_tdata", m_axis_tdata, 8'h11);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midreset_tvalid", m_axis_tvalid, 0);
    chk("midreset_read",   read, 0);
    chk("midreset_tdata",  m_axis_tdata, 0);
    chk("midreset_tlast",  m_axis_tlast, 0);
    src.delete(); set_empty();
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_stats();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("post_reset_stale", vcycles, 0);

`ifdef FIFO_RD_PKT_CNT_EN
    // Frame counter with random backpressure, then saturation.
    clear_stats();
    chk("cnt_reset", pkt_count, 0);
    rand_ready = 1'b1;
    load(1, 8'h01, 1);
    load(2, 8'h10, 2);
    load(64, 8'h20, 64);
    load(1, 8'h70, 1);
    load(300, 8'h00, 300);
    drain(3000);
    rand_ready = 1'b0; m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_rx("cnt_frames");
    chk("cnt_five", pkt_count, 5);
    dut.pkt_count = 16'hFFFF;
    clear_stats();
    load(3, 8'h55, 3);
    drain(50);
    chk("cnt_saturate", pkt_count, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_axis_stage.md
# fifo_rd_axis_stage

Read-side output stage of the Ethernet async FIFO, sitting directly downstream of the read-pointer block and the dual-port FIFO memory in the read clock domain. It decides when to pop the FIFO (drives `read`), absorbs the one-cycle synchronous RAM read latency, and presents words on an AXI-Stream master interface with full one-word-per-cycle throughput. A three-entry output buffer provides this throughput without any combinational path from `m_axis_tready` to `read`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload width; the RAM word is `DATA_WIDTH+1` bits, with MSB = tlast.

Ports:
- `clk`  in  1  read-domain clock
- `reset_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `empty`  in  1  registered FIFO-empty flag from the read-pointer block
- `read`  out  1  pop request to the read-pointer block; the word at the current `rd_addr` is consumed in this cycle
- `ram_rd_data`  in  DATA_WIDTH+1  synchronous RAM read port output; `[DATA_WIDTH]` = last flag
- `m_axis_tdata`  out  DATA_WIDTH  stream payload
- `m_axis_tlast`  out  1  end of frame
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `pkt_count`  out  16  frames emitted; present only with `FIFO_RD_PKT_CNT_EN`

## Operation
- Buffer: 3-entry circular store with 2-bit write and read indices (wrap 2→0) and occupancy `occ` in 0..3.
- `inflight`: register, set to the value of `read` each cycle. It marks that `ram_rd_data` holds a valid word this cycle.
- Pop rule: `read = !empty && (occ + inflight) < 3 && reset_n`. This depends only on registered state, so `m_axis_tready` has no combinational path to `read`.
- Capture: when `inflight`=1, write `ram_rd_data` into the slot at the write index and advance the write index.
- Output: `m_axis_tvalid = (occ != 0)`. `m_axis_tdata` and `m_axis_tlast` come from the slot at the read index, driven from registered buffer storage.
- Handshake: `tvalid && tready` advances the read index.
- `occ_next = occ + inflight - handshake`. A capture and a handshake in the same cycle leave `occ` unchanged.
- AXI rules:
  - Once `tvalid` is asserted, `tdata`/`tlast` stay stable until the handshake.
  - `tvalid` does not wait on `tready`.
- The credit rule guarantees no overflow: `occ + inflight` ≤ 3 always. A capture into a full buffer is a design error; flag it with an assertion in simulation.

## Timing
- Reset values (immediately on `reset_n` low, asynchronous):
  - `read`=0, `inflight`=0, `occ`=0, indices=0
  - all slots=0, so `tdata`=0, `tlast`=0, `tvalid`=0
  - `pkt_count`=0
- Latency: `read` high in cycle t → RAM word valid at t+1 → captured at the end of t+1 → `tvalid` high in t+2. First-word latency from `empty` falling is 2 cycles.
- Throughput: with `tready` held high and FIFO non-empty, `read` stays high every cycle and one word is emitted per cycle. Steady state is `occ`=1, `inflight`=1.
- Backpressure: with `tready` low, at most 3 words accumulate. `read` drops in the cycle where `occ + inflight` reaches 3 and re-asserts the cycle after a handshake frees a slot.
- `empty` rising mid-burst: `read` drops in the same cycle. Words already in flight are still captured and delivered.
- Reset mid-operation: buffered and in-flight words are discarded. The read-pointer block is reset together with this stage, so no pointer desync occurs.

## Configuration
- `FIFO_RD_PKT_CNT_EN` defined:
  - `pkt_count` port exists.
  - It increments by 1 on every handshake with `m_axis_tlast`=1 and saturates at 16'hFFFF.
  - It is reset to 0.
- `FIFO_RD_PKT_CNT_EN` undefined: the port and counter are absent, and the remaining behaviour is identical.

## Test plan
- Reset: assert `reset_n`=0 mid-clock with `occ`=2 → `tvalid`, `read`, `tdata`, `tlast` go to 0 immediately, with no clock edge needed; after release, no stale word is emitted.
- Single word: FIFO holds 0xA5 with last=1, `tready`=1 → `read` pulses for 1 cycle, and 2 cycles later `tvalid`=1, `tdata`=0xA5, `tlast`=1 for exactly 1 cycle.
- Full-rate burst: 256 words 0x00..0xFF, `tready`=1 → after 2-cycle latency, 256 consecutive `tvalid` cycles in order with no bubbles.
- Backpressure: burst of 20 words, `tready` low for 10 cycles mid-burst → `read` stops after `occ + inflight`=3, and all 20 words arrive in order with no loss or duplication.
- Underflow edge: `empty` toggles every 2 cycles during a burst → no read while `empty`=1, and the output sequence matches the write order.
- Counter (macro on): 5 frames of lengths 1, 2, 64, 1, 300, with random `tready` → `pkt_count`=5; preload the counter to 16'hFFFF and send one more frame → it stays 16'hFFFF.
